// File: rtl/imem_loader.sv
// Byte-stream loader that writes little-endian 32-bit words into IMEM from address 0.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module imem_loader #(
  parameter int addr_width_IMEM = 8
) (
  input  logic                       clk,
  input  logic                       async_reset_n,
  input  logic                       start,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       imem_we,
  output logic [addr_width_IMEM-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       core_hold,
  output logic                       done,
  output logic                       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [16:0] DEPTH = 17'd1 << (addr_width_IMEM - 2);
  localparam logic [addr_width_IMEM-1:0] ADDR_STEP = {{(addr_width_IMEM-3){1'b0}}, 3'b100};

  logic [2:0]  state_r;
  logic [2:0]  state_nx_s;
  logic [7:0]  count_lo_r;
  logic [15:0] words_left_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_buf_r;
  logic        accept_s;
  logic [15:0] count_s;
  logic        overflow_s;
`ifdef CHECKSUM_EN
  logic [7:0]  csum_acc_r;
`endif

  assign accept_s   = rx_valid & rx_ready;
  assign count_s    = {rx_data, count_lo_r};
  assign overflow_s = ({1'b0, count_s} > DEPTH);

  function automatic logic rx_state(input logic [2:0] s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) state_nx_s = S_HDR0;
        else       state_nx_s = state_r;
      end
      S_HDR0: begin
        if (accept_s) state_nx_s = S_HDR1;
        else          state_nx_s = S_HDR0;
      end
      S_HDR1: begin
        if (!accept_s)               state_nx_s = S_HDR1;
        else if (count_s == 16'd0)   state_nx_s = S_DONE;
        else if (overflow_s)         state_nx_s = S_IDLE;
        else                         state_nx_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) state_nx_s = S_WRITE;
        else                                  state_nx_s = S_DATA;
      end
      S_WRITE: begin
        // words_left is tested before its decrement, so 1 means this is the last word.
        if (words_left_r == 16'd1) begin
`ifdef CHECKSUM_EN
          state_nx_s = S_CSUM;
`else
          state_nx_s = S_DONE;
`endif
        end else begin
          state_nx_s = S_DATA;
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) state_nx_s = S_DONE;
        else          state_nx_s = S_CSUM;
      end
`endif
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, registered handshake/strobe outputs and load datapath.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_r      <= S_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0000_0000;
      core_hold    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      count_lo_r   <= 8'h00;
      words_left_r <= 16'h0000;
      byte_idx_r   <= 2'd0;
      word_buf_r   <= 24'h00_0000;
`ifdef CHECKSUM_EN
      csum_acc_r   <= 8'h00;
`endif
    end else begin
      state_r  <= state_nx_s;
      rx_ready <= rx_state(state_nx_s);
      imem_we  <= (state_nx_s == S_WRITE);
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_addr  <= '0;
            byte_idx_r <= 2'd0;
`ifdef CHECKSUM_EN
            csum_acc_r <= 8'h00;
`endif
          end else if (state_r == S_DONE) begin
            done      <= 1'b1;
            core_hold <= 1'b0;
          end
        end
        S_HDR0: begin
          if (accept_s) count_lo_r <= rx_data;
        end
        S_HDR1: begin
          if (accept_s) begin
            words_left_r <= count_s;
            if (overflow_s) begin
              err       <= 1'b1;
              core_hold <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (accept_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef CHECKSUM_EN
            csum_acc_r <= csum_acc_r ^ rx_data;
`endif
            case (byte_idx_r)
              2'd0:    word_buf_r[7:0]   <= rx_data;
              2'd1:    word_buf_r[15:8]  <= rx_data;
              2'd2:    word_buf_r[23:16] <= rx_data;
              default: imem_wdata        <= {rx_data, word_buf_r};
            endcase
          end
        end
        S_WRITE: begin
          imem_addr    <= imem_addr + ADDR_STEP;
          words_left_r <= words_left_r - 16'd1;
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (accept_s && (rx_data != csum_acc_r)) err <= 1'b1;
        end
`endif
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes are queued by the stimulus
// and popped by a write monitor; status outputs are compared inline.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_e;
  logic [7:0]  prog [0:9];

  always #5 clk = ~clk;

  imem_loader #(.addr_width_IMEM(AW)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (async_reset_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", imem_addr, imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(exp_e[39:32]));
        check("write_data", imem_wdata, exp_e[31:0]);
      end
      check("ready_in_write", 32'(rx_ready), 32'd0);
    end
  end

  task automatic expect_write(input logic [7:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        check("byte_accept_timeout", 32'(rx_ready), 32'd1);
        break;
      end
    end
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done", 32'(done), 32'd1);
  endtask

  // Two-word program image, optionally followed by a checksum byte.
  task automatic send_prog(input bit gap, input bit with_csum, input logic [7:0] csum);
    expect_write(8'h00, 32'h0000_0013);
    expect_write(8'h04, 32'h0010_0093);
    for (int i = 0; i < 10; i++) send_byte(prog[i], gap);
    if (with_csum) send_byte(csum, gap);
    rx_valid = 1'b0;
  endtask

  initial begin
    prog = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    async_reset_n = 1'b0;
    start = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 async_reset_n = 1'b1;
    check("reset_rx_ready", 32'(rx_ready), 32'd0);
    check("reset_core_hold", 32'(core_hold), 32'd0);

    // Two-word load with valid held high.
    pulse_start();
    check("hdr_core_hold", 32'(core_hold), 32'd1);
`ifdef CHECKSUM_EN
    send_prog(1'b0, 1'b1, 8'h90);
`else
    send_prog(1'b0, 1'b0, 8'h00);
`endif
    wait_done();
    check("t2_core_hold", 32'(core_hold), 32'd0);
    check("t2_err", 32'(err), 32'd0);
    check("t2_addr", 32'(imem_addr), 32'h08);

    // Mid-cycle reset clears every output at once.
    @(posedge clk); #2 async_reset_n = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {29'd0, rx_ready, imem_we, err}, 32'd0);
    @(negedge clk); async_reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready_we", {30'd0, rx_ready, imem_we}, 32'd0);
    end

    // Same image with valid toggling.
    pulse_start();
`ifdef CHECKSUM_EN
    send_prog(1'b1, 1'b1, 8'h90);
`else
    send_prog(1'b1, 1'b0, 8'h00);
`endif
    wait_done();
    check("t3_err", 32'(err), 32'd0);

    // Zero-length image.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("t4_done", 32'(done), 32'd1);
    check("t4_core_hold", 32'(core_hold), 32'd0);
    check("t4_addr", 32'(imem_addr), 32'd0);

    // Header overflow: 65 words into a 64-word memory.
    pulse_start();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_data = 8'h55;
    @(posedge clk); #1;
    check("t5_err", 32'(err), 32'd1);
    check("t5_hold_done", {30'd0, core_hold, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_consume", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

    // Reset after two data bytes: no write, then a clean reload.
    pulse_start();
    check("t5_err_cleared", 32'(err), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rx_valid = 1'b0;
    #2 async_reset_n = 1'b0;
    #1 check("abort_we_hold", {30'd0, imem_we, core_hold}, 32'd0);
    @(negedge clk); async_reset_n = 1'b1;
    pulse_start();
    expect_write(8'h00, 32'h1234_5678);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
`ifdef CHECKSUM_EN
    send_byte(8'h08, 1'b0);
`endif
    rx_valid = 1'b0;
    wait_done();
    check("reload_err", 32'(err), 32'd0);
    check("reload_addr", 32'(imem_addr), 32'h04);

`ifdef CHECKSUM_EN
    // Checksum good then bad.
    pulse_start();
    send_prog(1'b0, 1'b1, 8'h90);
    wait_done();
    check("t6_good_err", 32'(err), 32'd0);
    pulse_start();
    send_prog(1'b0, 1'b1, 8'h91);
    wait_done();
    check("t6_bad_err", 32'(err), 32'd1);
    check("t6_core_hold", 32'(core_hold), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
